// File: rtl/mapper_sched.sv
// rtl/mapper_sched.sv - bit-to-symbol scheduler feeding the QAM mapper
//
// Slices a framed byte stream into per-symbol bit groups of the order latched
// at start of frame, splits each group into re/im indices and issues one
// registered mapper request per symbol. Everything is gated by iclkena.
//
// Optional feature macro: MAPPER_SCHED_PAD_EN
//   defined   : a short residual at end of frame is zero-padded into a last symbol
//   undefined : the residual is discarded; a frame with no full symbol pulses odrop
//
// Ports
//   iclk     in   clock
//   ireset   in   asynchronous reset, active-low
//   iclkena  in   global clock enable (shared with the mapper)
//   ival     in   input byte valid
//   isop     in   first byte of frame, qualifies iqam
//   ieop     in   last byte of frame
//   iqam     in   [3:0] bits per symbol (1..10)
//   idat     in   [7:0] data byte, MSB first
//   ordy     out  byte accepted when ival & ordy & iclkena
//   oval     out  mapper request valid (one-cycle pulse per symbol)
//   osop     out  first symbol of frame
//   oeop     out  last symbol of frame
//   oqam     out  [3:0] latched order
//   odat_re  out  [4:0] re index
//   odat_im  out  [4:0] im index
//   odrop    out  one-cycle pulse: frame aborted or yielded no symbol
module mapper_sched #(
  parameter int pBUF_W   = 18,
  parameter int pDEF_QAM = 2
) (
  input  logic       iclk,
  input  logic       ireset,
  input  logic       iclkena,
  input  logic       ival,
  input  logic       isop,
  input  logic       ieop,
  input  logic [3:0] iqam,
  input  logic [7:0] idat,
  output logic       ordy,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic [3:0] oqam,
  output logic [4:0] odat_re,
  output logic [4:0] odat_im,
  output logic       odrop
);

`ifdef MAPPER_SCHED_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [3:0] DEF_QAM = 4'(pDEF_QAM);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [pBUF_W-1:0] bbuf, bbuf_nxt;   // oldest bit at the MSB, unused bits always 0
  logic [4:0]        cnt, cnt_nxt;
  logic              sop_pend, sop_pend_nxt;
  logic [3:0]        qam_nxt;
  logic              oval_nxt, osop_nxt, oeop_nxt, odrop_nxt;
  logic [4:0]        re_nxt, im_nxt;

  logic              acc, take, restart, full, pad, emit, flushing, last;
  logic [3:0]        qam_new, n, nim;
  logic [pBUF_W-1:0] base_buf, comb_buf;
  logic [4:0]        base_cnt, tot, rem;
  logic [9:0]        win, sym;
  logic [pBUF_W-1:0] byte_msb;

  assign byte_msb = {idat, {(pBUF_W-8){1'b0}}};
  assign ordy     = (state != FLUSH) & (cnt <= 5'd9) & iclkena;

  always_comb begin
    acc      = ival & ordy;
    // Outside a frame only an isop byte is taken; anything else is acknowledged and dropped.
    take     = acc & (isop | (state == RUN));
    restart  = acc & isop;
    qam_new  = ((iqam >= 4'd1) && (iqam <= 4'd10)) ? iqam : DEF_QAM;
    n        = restart ? qam_new : oqam;
    base_buf = restart ? '0 : bbuf;
    base_cnt = restart ? 5'd0 : cnt;

    // The arriving byte is merged before the symbol decision so a symbol completed
    // by this byte is issued on the same edge that accepts it.
    comb_buf = base_buf | (take ? (byte_msb >> base_cnt) : '0);
    tot      = base_cnt + (take ? 5'd8 : 5'd0);

    full     = (tot >= {1'b0, n});
    pad      = PAD_EN & (state == FLUSH) & !full & (tot != 5'd0);
    emit     = full | pad;
    rem      = full ? (tot - {1'b0, n}) : 5'd0;
    flushing = (state == FLUSH) | (take & ieop);
    // Last symbol: nothing usable remains once this one leaves.
    last     = flushing & (PAD_EN ? (pad | (full & (rem == 5'd0)))
                                  : (full & (rem < {1'b0, n})));

    // Padding needs no special case: bits below cnt are always zero.
    win      = comb_buf[pBUF_W-1 -: 10];
    sym      = win >> (4'd10 - n);
    nim      = n >> 1;

    state_nxt    = state;
    bbuf_nxt     = emit ? (comb_buf << n) : comb_buf;
    cnt_nxt      = pad ? 5'd0 : (emit ? rem : tot);
    qam_nxt      = restart ? qam_new : oqam;
    sop_pend_nxt = (restart | sop_pend) & !emit;
    oval_nxt     = emit;
    osop_nxt     = emit & (restart | sop_pend);
    oeop_nxt     = last;
    re_nxt       = emit ? 5'(sym >> nim) : odat_re;
    im_nxt       = emit ? 5'(sym & ((10'd1 << nim) - 10'd1)) : odat_im;
    odrop_nxt    = restart & (state == RUN);

    if (take) state_nxt = ieop ? FLUSH : RUN;

    if (last) begin
      state_nxt = IDLE;
      bbuf_nxt  = '0;
      cnt_nxt   = 5'd0;
    end else if ((state == FLUSH) && !emit) begin
      // Residual discarded; flag the frame if it never produced a symbol.
      state_nxt = IDLE;
      bbuf_nxt  = '0;
      cnt_nxt   = 5'd0;
      odrop_nxt = sop_pend;
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state    <= IDLE;
      bbuf     <= '0;
      cnt      <= 5'd0;
      sop_pend <= 1'b0;
      oqam     <= DEF_QAM;
      oval     <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      odat_re  <= 5'd0;
      odat_im  <= 5'd0;
      odrop    <= 1'b0;
    end else if (iclkena) begin
      state    <= state_nxt;
      bbuf     <= bbuf_nxt;
      cnt      <= cnt_nxt;
      sop_pend <= sop_pend_nxt;
      oqam     <= qam_nxt;
      oval     <= oval_nxt;
      osop     <= osop_nxt;
      oeop     <= oeop_nxt;
      odat_re  <= re_nxt;
      odat_im  <= im_nxt;
      odrop    <= odrop_nxt;
    end
  end

endmodule

// File: tb/tb_mapper_sched.sv
// tb/tb_mapper_sched.sv - directed self-checking bench for mapper_sched
module tb_mapper_sched;

  logic       iclk = 1'b0;
  logic       ireset = 1'b0;
  logic       iclkena = 1'b1;
  logic       ival = 1'b0, isop = 1'b0, ieop = 1'b0;
  logic [3:0] iqam = 4'd0;
  logic [7:0] idat = 8'd0;
  logic       ordy, oval, osop, oeop, odrop;
  logic [3:0] oqam;
  logic [4:0] odat_re, odat_im;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 iclk = ~iclk;

  mapper_sched dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .ival(ival), .isop(isop), .ieop(ieop), .iqam(iqam), .idat(idat),
    .ordy(ordy), .oval(oval), .osop(osop), .oeop(oeop), .oqam(oqam),
    .odat_re(odat_re), .odat_im(odat_im), .odrop(odrop)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // packed {odrop, oval, osop, oeop, re, im}
  task automatic sym(input string tag, input logic d, input logic v, input logic s,
                     input logic e, input logic [4:0] re, input logic [4:0] im);
    chk(tag, {2'b00, odrop, oval, osop, oeop, odat_re, odat_im},
             {2'b00, d, v, s, e, re, im});
  endtask

  task automatic step();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic put(input logic v, input logic s, input logic e,
                     input logic [3:0] q, input logic [7:0] d);
    ival = v; isop = s; ieop = e; iqam = q; idat = d;
  endtask

  initial begin
    @(negedge iclk);
    sym("reset_out", 0, 0, 0, 0, 5'd0, 5'd0);
    chk("reset_oqam", 16'(oqam), 16'd2);
    chk("reset_ordy", 16'(ordy), 16'd1);
    ireset = 1'b1;

    // QPSK single byte
    put(1, 1, 1, 4'd2, 8'hB4);
    step(); sym("qpsk_0", 0, 1, 1, 0, 5'd1, 5'd0);
    chk("qpsk_flush_ordy", 16'(ordy), 16'd0);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); sym("qpsk_1", 0, 1, 0, 0, 5'd1, 5'd1);
    step(); sym("qpsk_2", 0, 1, 0, 0, 5'd0, 5'd1);
    step(); sym("qpsk_3", 0, 1, 0, 1, 5'd0, 5'd0);
    step(); chk("qpsk_idle", 16'(oval), 16'd0);
    chk("qpsk_ordy", 16'(ordy), 16'd1);

    // 16QAM single byte
    put(1, 1, 1, 4'd4, 8'hB4);
    step(); sym("q16_0", 0, 1, 1, 0, 5'd2, 5'd3);
    chk("q16_oqam", 16'(oqam), 16'd4);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); sym("q16_1", 0, 1, 0, 1, 5'd1, 5'd0);

    // 256QAM two bytes
    put(1, 1, 0, 4'd8, 8'hB4);
    step(); sym("q256_0", 0, 1, 1, 0, 5'd11, 5'd4);
    put(1, 0, 1, 4'd0, 8'h3C);
    step(); sym("q256_1", 0, 1, 0, 1, 5'd3, 5'd12);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); chk("q256_idle", 16'(oval), 16'd0);

    // 8QAM single byte, residual of 2 bits
    put(1, 1, 1, 4'd3, 8'hB4);
    step(); sym("q8_0", 0, 1, 1, 0, 5'd2, 5'd1);
    put(0, 0, 0, 4'd0, 8'h00);
`ifdef MAPPER_SCHED_PAD_EN
    step(); sym("q8_1", 0, 1, 0, 0, 5'd2, 5'd1);
    step(); sym("q8_pad", 0, 1, 0, 1, 5'd0, 5'd0);
`else
    step(); sym("q8_1", 0, 1, 0, 1, 5'd2, 5'd1);
`endif
    step(); chk("q8_idle", 16'(oval), 16'd0);

    // n=10, one byte never fills a symbol
    put(1, 1, 1, 4'd10, 8'hB4);
    step(); chk("q1k_wait", {14'd0, odrop, oval}, 16'd0);
    put(0, 0, 0, 4'd0, 8'h00);
`ifdef MAPPER_SCHED_PAD_EN
    step(); sym("q1k_pad", 0, 1, 1, 1, 5'h16, 5'h10);
`else
    step(); chk("q1k_drop", {14'd0, odrop, oval}, 16'd2);
`endif
    step(); chk("q1k_after", {14'd0, odrop, oval}, 16'd0);

    // Out-of-range order falls back to QPSK
    put(1, 1, 1, 4'd12, 8'hB4);
    step(); sym("qdef_0", 0, 1, 1, 0, 5'd1, 5'd0);
    chk("qdef_oqam", 16'(oqam), 16'd2);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); step();
    step(); sym("qdef_3", 0, 1, 0, 1, 5'd0, 5'd0);

    // Clock-enable hold mid-frame, 16QAM {B4,3C}
    put(1, 1, 0, 4'd4, 8'hB4);
    step(); sym("ce_0", 0, 1, 1, 0, 5'd2, 5'd3);
    iclkena = 1'b0;
    put(1, 0, 1, 4'd0, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      step();
      sym("ce_hold", 0, 1, 1, 0, 5'd2, 5'd3);
      chk("ce_ordy", 16'(ordy), 16'd0);
    end
    iclkena = 1'b1;
    step(); sym("ce_1", 0, 1, 0, 0, 5'd1, 5'd0);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); sym("ce_2", 0, 1, 0, 0, 5'd0, 5'd3);
    step(); sym("ce_3", 0, 1, 0, 1, 5'd3, 5'd0);

    // isop while in RUN aborts and restarts
    put(1, 1, 0, 4'd2, 8'hA5);
    step(); sym("abort_0", 0, 1, 1, 0, 5'd1, 5'd0);
    put(1, 1, 1, 4'd4, 8'hB4);
    step(); sym("abort_restart", 1, 1, 1, 0, 5'd2, 5'd3);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); sym("abort_end", 0, 1, 0, 1, 5'd1, 5'd0);

    // Async reset mid-FLUSH, n=1
    put(1, 1, 1, 4'd1, 8'hB4);
    step(); sym("rst_0", 0, 1, 1, 0, 5'd1, 5'd0);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); sym("rst_1", 0, 1, 0, 0, 5'd0, 5'd0);
    #2 ireset = 1'b0;
    #1 sym("rst_async", 0, 0, 0, 0, 5'd0, 5'd0);
    chk("rst_oqam", 16'(oqam), 16'd2);
    chk("rst_ordy", 16'(ordy), 16'd1);
    step(); chk("rst_nodrop", 16'(odrop), 16'd0);
    ireset = 1'b1;
    put(1, 1, 1, 4'd2, 8'hB4);
    step(); sym("rst_again", 0, 1, 1, 0, 5'd1, 5'd0);
    put(0, 0, 0, 4'd0, 8'h00);
    step(); step();
    step(); sym("rst_again_end", 0, 1, 0, 1, 5'd0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
